pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the stall performance counter.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 dec_rs1, dec_rs2  input  5 each  source registers of the instruction in decode.
REQ-006 dec_use_rs1, dec_use_rs2  input  1 each  decode instruction actually reads rs1/rs2.
REQ-007 ex_valid  input  1  exec stage holds a real (non-bubble) instruction.
REQ-008 ex_is_load  input  1  exec instruction is a load.
REQ-009 ex_rd  input  5  exec destination register.
REQ-010 br_taken  input  1  exec resolved a taken branch/jump this cycle.
REQ-011 br_target  input  32  redirect address, valid with br_taken.
REQ-012 mem_req  input  1  exec requests data memory this cycle.
REQ-013 mem_ready  input  1  data memory completes the request this cycle.
REQ-014 halt_req  input  1  exec retires ecall/illegal; processor halts.
REQ-015 pc  output  32  registered fetch address, drives fetch-to-decode addr.
REQ-016 fd_stall, fd_flush  output  1 each  hold / zero the fetch-to-decode register.
REQ-017 de_stall, de_flush  output  1 each  hold / zero (bubble) the decode-to-exec register.
REQ-018 state  output  2  RUN=0, MEM_WAIT=1, HALT=2; 3 unused.
REQ-019 stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-020 Stall/flush outputs SHALL be combinational from state and inputs; pc, state, stall_cnt SHALL be registered.
REQ-021 mem_stall = mem_req & ~mem_ready; lu_hazard = ex_valid & ex_is_load & ex_rd!=0 & ((dec_use_rs1 & dec_rs1==ex_rd) | (dec_use_rs2 & dec_rs2==ex_rd)).
REQ-022 Priority, highest first: HALT state, mem_stall, halt_req, br_taken, lu_hazard, normal advance.
REQ-023 RUN, mem_stall: fd_stall=de_stall=1, flushes 0, pc held, next state MEM_WAIT.
REQ-024 MEM_WAIT, mem_ready=0: same outputs as REQ-023, remain MEM_WAIT; exec holds its instruction so br_taken/halt_req persist.
REQ-025 MEM_WAIT, mem_ready=1: stalls released, lower-priority conditions evaluated same cycle as in RUN, next state RUN (or HALT per REQ-026).
REQ-026 halt_req (not mem-stalled): fd_flush=de_flush=1, pc held, next state HALT.
REQ-027 HALT: fd_stall=de_stall=1 and fd_flush=de_flush=1, pc frozen, inputs ignored; exit only by RST.
REQ-028 br_taken: fd_flush=de_flush=1, pc<=br_target next edge; lu_hazard ignored that cycle (wrong-path instruction).
REQ-029 lu_hazard: fd_stall=1, de_flush=1 (one bubble), pc held; hazard clears next cycle as load leaves exec.
REQ-030 Normal advance: all stall/flush 0, pc<=pc+4, wrapping 32'hFFFF_FFFC -> 0.
REQ-031 br_target SHALL be loaded unmodified; low bits are not masked.
REQ-032 stall_cnt SHALL increment when fd_stall=1 and state!=HALT, saturating at all-ones.
REQ-033 Register x0 SHALL never produce a load-use hazard.

Reset
REQ-034 RST asserted SHALL immediately (no clock) force pc=RESET_PC, state=RUN, stall_cnt=0.
REQ-035 While RST=1 outputs SHALL be fd_flush=de_flush=1, stalls 0; reset mid-MEM_WAIT or HALT SHALL discard all pending state.
REQ-036 First edge after RST deassert SHALL fetch RESET_PC with pc advancing to RESET_PC+4.

Verification
REQ-037 Reset then 3 free cycles -> pc 0,4,8,12; all stall/flush 0; stall_cnt 0.
REQ-038 ex_valid=1, ex_is_load=1, ex_rd=5, dec_use_rs2=1, dec_rs2=5 for one cycle -> fd_stall=1, de_flush=1, pc held 1 cycle, stall_cnt 1; same with ex_rd=0 -> no stall.
REQ-039 pc=0x40, br_taken=1, br_target=0x100 with concurrent lu_hazard -> fd_flush=de_flush=1, fd_stall=0, next pc=0x100.
REQ-040 mem_req=1, mem_ready=0 for 3 cycles with br_taken=1, then mem_ready=1 -> state MEM_WAIT 3 cycles, pc held, stall_cnt +3, redirect taken on ready cycle.
REQ-041 halt_req=1 -> state HALT, pc frozen, further br_taken ignored; assert RST mid-HALT asynchronously -> pc=RESET_PC, state RUN before next edge.
REQ-042 CNT_W=4, hold mem_stall 20 cycles -> stall_cnt saturates at 15; pc forced near 32'hFFFF_FFFC free-run -> wraps to 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The master side drives decode/exec/memory status; the slave side returns pc and stall/flush.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       dec_rs1;
    logic [4:0]       dec_rs2;
    logic             dec_use_rs1;
    logic             dec_use_rs2;
    logic             ex_valid;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic             br_taken;
    logic [31:0]      br_target;
    logic             mem_req;
    logic             mem_ready;
    logic             halt_req;
    logic [31:0]      pc;
    logic             fd_stall;
    logic             fd_flush;
    logic             de_stall;
    logic             de_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               ex_valid, ex_is_load, ex_rd, br_taken, br_target,
               mem_req, mem_ready, halt_req,
        input  pc, fd_stall, fd_flush, de_stall, de_flush, state, stall_cnt
    );

    modport slave (
        input  dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
               ex_valid, ex_is_load, ex_rd, br_taken, br_target,
               mem_req, mem_ready, halt_req,
        output pc, fd_stall, fd_flush, de_stall, de_flush, state, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: fetch PC, stall/flush steering for the F/D and D/E registers,
// memory-wait and halt tracking, and a saturating stalled-cycle counter.
module pipe_hazard_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input logic              CLK,
    input logic              RST,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    logic [31:0]      r_pc;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_mem_stall;
    logic             w_lu_hazard;
    logic             w_fd_stall;
    logic             w_fd_flush;
    logic             w_de_stall;
    logic             w_de_flush;
    logic [31:0]      w_pc_nxt;
    logic [1:0]       w_state_nxt;

    // Once waiting, only mem_ready releases the stall; exec keeps its request pending.
    always_comb begin
        w_mem_stall = 1'b0;
        if (r_state == ST_MEM_WAIT) begin
            w_mem_stall = ~bus.mem_ready;
        end else begin
            w_mem_stall = bus.mem_req & ~bus.mem_ready;
        end
    end

    always_comb begin
        w_lu_hazard = bus.ex_valid & bus.ex_is_load & (bus.ex_rd != 5'd0) &
                      ((bus.dec_use_rs1 & (bus.dec_rs1 == bus.ex_rd)) |
                       (bus.dec_use_rs2 & (bus.dec_rs2 == bus.ex_rd)));
    end

    always_comb begin
        w_fd_stall  = 1'b0;
        w_fd_flush  = 1'b0;
        w_de_stall  = 1'b0;
        w_de_flush  = 1'b0;
        w_pc_nxt    = r_pc + 32'd4;
        w_state_nxt = ST_RUN;
        if (r_state == ST_HALT) begin
            w_fd_stall  = 1'b1;
            w_fd_flush  = 1'b1;
            w_de_stall  = 1'b1;
            w_de_flush  = 1'b1;
            w_pc_nxt    = r_pc;
            w_state_nxt = ST_HALT;
        end else if (w_mem_stall) begin
            w_fd_stall  = 1'b1;
            w_de_stall  = 1'b1;
            w_pc_nxt    = r_pc;
            w_state_nxt = ST_MEM_WAIT;
        end else if (bus.halt_req) begin
            w_fd_flush  = 1'b1;
            w_de_flush  = 1'b1;
            w_pc_nxt    = r_pc;
            w_state_nxt = ST_HALT;
        end else if (bus.br_taken) begin
            // Redirect wins over a load-use hazard: the decode instruction is wrong-path.
            w_fd_flush  = 1'b1;
            w_de_flush  = 1'b1;
            w_pc_nxt    = bus.br_target;
        end else if (w_lu_hazard) begin
            w_fd_stall  = 1'b1;
            w_de_flush  = 1'b1;
            w_pc_nxt    = r_pc;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc        <= RESET_PC;
            r_state     <= ST_RUN;
            r_stall_cnt <= '0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_state <= w_state_nxt;
            if (w_fd_stall && (r_state != ST_HALT) && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // While reset is held, both pipeline registers are flushed and nothing stalls.
    assign bus.fd_stall  = ~RST & w_fd_stall;
    assign bus.de_stall  = ~RST & w_de_stall;
    assign bus.fd_flush  = RST | w_fd_flush;
    assign bus.de_flush  = RST | w_de_flush;
    assign bus.pc        = r_pc;
    assign bus.state     = r_state;
    assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a rule-level model checked every negedge,
// plus hand-computed literal expectations along the stimulus.
module tb_pipe_hazard_ctrl;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 CLK = ~CLK;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

    pipe_hazard_ctrl #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .bus(bus.slave));
    pipe_hazard_ctrl #(.RESET_PC(RST_PC), .CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .bus(bus4.slave));

    assign bus4.dec_rs1     = bus.dec_rs1;
    assign bus4.dec_rs2     = bus.dec_rs2;
    assign bus4.dec_use_rs1 = bus.dec_use_rs1;
    assign bus4.dec_use_rs2 = bus.dec_use_rs2;
    assign bus4.ex_valid    = bus.ex_valid;
    assign bus4.ex_is_load  = bus.ex_is_load;
    assign bus4.ex_rd       = bus.ex_rd;
    assign bus4.br_taken    = bus.br_taken;
    assign bus4.br_target   = bus.br_target;
    assign bus4.mem_req     = bus.mem_req;
    assign bus4.mem_ready   = bus.mem_ready;
    assign bus4.halt_req    = bus.halt_req;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: classify each cycle into one action, then derive everything from it.
    localparam int A_HALTED = 0, A_WAIT = 1, A_HALT = 2, A_BRANCH = 3, A_BUBBLE = 4, A_ADV = 5;

    logic [31:0] m_pc;
    int          m_st;
    int          m_c16;
    int          m_c4;

    function automatic int get_act();
        bit waiting;
        bit hazard;
        waiting = (m_st == 1) ? !bus.mem_ready : (bus.mem_req && !bus.mem_ready);
        hazard  = bus.ex_valid && bus.ex_is_load && (bus.ex_rd != 0) &&
                  ((bus.dec_use_rs1 && bus.dec_rs1 == bus.ex_rd) ||
                   (bus.dec_use_rs2 && bus.dec_rs2 == bus.ex_rd));
        if (m_st == 2)        return A_HALTED;
        if (waiting)          return A_WAIT;
        if (bus.halt_req)     return A_HALT;
        if (bus.br_taken)     return A_BRANCH;
        if (hazard)           return A_BUBBLE;
        return A_ADV;
    endfunction

    // {fd_stall, fd_flush, de_stall, de_flush}
    function automatic logic [3:0] act_ctl(input int a);
        case (a)
            A_HALTED: return 4'b1111;
            A_WAIT:   return 4'b1010;
            A_HALT:   return 4'b0101;
            A_BRANCH: return 4'b0101;
            A_BUBBLE: return 4'b1001;
            default:  return 4'b0000;
        endcase
    endfunction

    always @(posedge CLK or posedge RST) begin : model
        int a;
        if (RST) begin
            m_pc  <= RST_PC;
            m_st  <= 0;
            m_c16 <= 0;
            m_c4  <= 0;
        end else begin
            a = get_act();
            if (a == A_BRANCH)      m_pc <= bus.br_target;
            else if (a == A_ADV)    m_pc <= m_pc + 32'd4;
            m_st <= (a == A_HALTED || a == A_HALT) ? 2 : (a == A_WAIT) ? 1 : 0;
            if (act_ctl(a)[3] && a != A_HALTED) begin
                if (m_c16 < 65535) m_c16 <= m_c16 + 1;
                if (m_c4 < 15)     m_c4  <= m_c4 + 1;
            end
        end
    end

    always @(negedge CLK) begin : compare
        logic [3:0] e;
        if (RST) begin
            e = 4'b0101;
            chk("pc_rst", bus.pc, RST_PC);
            chk("state_rst", 32'(bus.state), 32'd0);
            chk("cnt_rst", 32'(bus.stall_cnt), 32'd0);
        end else begin
            e = act_ctl(get_act());
            chk("pc", bus.pc, m_pc);
            chk("state", 32'(bus.state), m_st);
            chk("cnt16", 32'(bus.stall_cnt), m_c16);
            chk("cnt4", 32'(bus4.stall_cnt), m_c4);
        end
        chk("ctl", {28'd0, bus.fd_stall, bus.fd_flush, bus.de_stall, bus.de_flush}, {28'd0, e});
    end

    task automatic clr_in();
        bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0;
        bus.dec_use_rs1 = 1'b0; bus.dec_use_rs2 = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_is_load = 1'b0; bus.ex_rd = 5'd0;
        bus.br_taken = 1'b0; bus.br_target = 32'd0;
        bus.mem_req = 1'b0; bus.mem_ready = 1'b0; bus.halt_req = 1'b0;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic u1, input logic [4:0] r1,
                            input logic u2, input logic [4:0] r2);
        bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = rd;
        bus.dec_use_rs1 = u1; bus.dec_rs1 = r1;
        bus.dec_use_rs2 = u2; bus.dec_rs2 = r2;
    endtask

    logic [31:0] pc_save;
    logic [31:0] cnt_save;

    initial begin
        clr_in();
        #2;
        chk("lit_rst_pc", bus.pc, 32'h0);
        chk("lit_rst_flush", {30'd0, bus.fd_flush, bus.de_flush}, 32'd3);
        chk("lit_rst_stall", {30'd0, bus.fd_stall, bus.de_stall}, 32'd0);
        #10 RST = 1'b0;
        #1;
        chk("lit_pc0", bus.pc, 32'h0);
        cyc(); chk("lit_pc4", bus.pc, 32'h4);
        cyc(); chk("lit_pc8", bus.pc, 32'h8);
        cyc(); chk("lit_pc12", bus.pc, 32'hC);
        chk("lit_cnt0", 32'(bus.stall_cnt), 32'd0);

        // load-use on rs2
        set_load(5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
        #1;
        chk("lit_lu_ctl", {28'd0, bus.fd_stall, bus.fd_flush, bus.de_stall, bus.de_flush}, 32'b1001);
        cyc(); chk("lit_lu_pc", bus.pc, 32'hC);
        chk("lit_lu_cnt", 32'(bus.stall_cnt), 32'd1);
        set_load(5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
        #1; chk("lit_x0_stall", {31'd0, bus.fd_stall}, 32'd0);
        cyc(); chk("lit_x0_pc", bus.pc, 32'h10);
        set_load(5'd7, 1'b0, 5'd7, 1'b1, 5'd3);
        #1; chk("lit_nouse_stall", {31'd0, bus.fd_stall}, 32'd0);
        cyc();
        set_load(5'd9, 1'b1, 5'd9, 1'b0, 5'd0);
        cyc();
        clr_in();

        // branch to 0x40, then branch with concurrent hazard
        bus.br_taken = 1'b1; bus.br_target = 32'h40;
        cyc(); chk("lit_br40", bus.pc, 32'h40);
        set_load(5'd3, 1'b1, 5'd3, 1'b0, 5'd0);
        bus.br_target = 32'h100;
        #1;
        chk("lit_brlu_ctl", {28'd0, bus.fd_stall, bus.fd_flush, bus.de_stall, bus.de_flush}, 32'b0101);
        cyc(); chk("lit_br100", bus.pc, 32'h100);
        clr_in();
        bus.br_taken = 1'b1; bus.br_target = 32'h103;
        cyc(); chk("lit_br_unaligned", bus.pc, 32'h103);
        bus.br_target = 32'h200;
        cyc(); clr_in();

        // memory wait with pending branch
        pc_save = bus.pc; cnt_save = 32'(bus.stall_cnt);
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        bus.br_taken = 1'b1; bus.br_target = 32'h300;
        repeat (3) begin
            cyc();
            chk("lit_mw_state", 32'(bus.state), 32'd1);
            chk("lit_mw_pc", bus.pc, pc_save);
        end
        bus.mem_ready = 1'b1;
        #1; chk("lit_mw_rel", {28'd0, bus.fd_stall, bus.fd_flush, bus.de_stall, bus.de_flush}, 32'b0101);
        cyc();
        chk("lit_mw_br", bus.pc, 32'h300);
        chk("lit_mw_run", 32'(bus.state), 32'd0);
        chk("lit_mw_cnt", 32'(bus.stall_cnt), cnt_save + 32'd3);
        clr_in();

        // halt, ignore branches, asynchronous reset out of HALT
        bus.halt_req = 1'b1;
        cyc(); chk("lit_halt_state", 32'(bus.state), 32'd2);
        clr_in();
        bus.br_taken = 1'b1; bus.br_target = 32'h500;
        cnt_save = 32'(bus.stall_cnt);
        cyc(); cyc();
        chk("lit_halt_pc", bus.pc, 32'h300);
        chk("lit_halt_cnt", 32'(bus.stall_cnt), cnt_save);
        clr_in();
        #2 RST = 1'b1;
        #1;
        chk("lit_arst_pc", bus.pc, RST_PC);
        chk("lit_arst_state", 32'(bus.state), 32'd0);
        #3 RST = 1'b0;
        cyc(); chk("lit_arst_pc4", bus.pc, RST_PC + 32'd4);

        // reset in the middle of a memory wait
        bus.mem_req = 1'b1;
        cyc(); cyc();
        chk("lit_mw2_state", 32'(bus.state), 32'd1);
        #2 RST = 1'b1;
        #1 chk("lit_mw2_rst", 32'(bus.state), 32'd0);
        clr_in();
        #3 RST = 1'b0;
        cyc(); chk("lit_mw2_pc", bus.pc, 32'h4);

        // long memory stall saturates the narrow counter
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        repeat (20) cyc();
        chk("lit_sat4", 32'(bus4.stall_cnt), 32'd15);
        chk("lit_cnt16_20", 32'(bus.stall_cnt), 32'd20);
        bus.mem_ready = 1'b1;
        cyc(); clr_in();

        // PC wrap
        bus.br_taken = 1'b1; bus.br_target = 32'hFFFF_FFF4;
        cyc(); chk("lit_wrap_f4", bus.pc, 32'hFFFF_FFF4);
        clr_in();
        cyc(); cyc(); chk("lit_wrap_fc", bus.pc, 32'hFFFF_FFFC);
        cyc(); chk("lit_wrap_0", bus.pc, 32'h0);
        cyc();
        #6;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
